oq_pacing_arbiter: RTL

- Shares one 10G TX stream (MAC/port) between NUM_QUEUES output-queue AXI-Stream masters, such as the per-port outputs of the BRAM output queues.
- Grants whole packets in round-robin order.
- After each packet, the sending queue is held off for its own inter-packet delay (IPD). The IPD is counted in microsecond ticks from the utimer_clk strobe.
- Gives per-queue software-configurable pacing without stalling the enqueue side.

---
 rtl/oq_pacing_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/oq_pacing_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_QUEUES AXI-Stream queues onto one TX
// stream; after each packet the sender is held off for its programmed inter-packet delay.
module oq_pacing_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_QUEUES         = 5
) (
    input  logic                                           axi_aclk,
    input  logic                                           axi_resetn,
    input  logic                                           utimer_clk,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]      s_axis_tstrb,
    input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                          s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                          s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                          s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                 m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                  m_axis_tuser,
    output logic                                           m_axis_tvalid,
    output logic                                           m_axis_tlast,
    input  logic                                           m_axis_tready,
    input  logic [NUM_QUEUES*C_S_AXI_DATA_WIDTH-1:0]       ipd_value,
    output logic [NUM_QUEUES-1:0]                          pkt_sent,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                  bytes_sent,
    output logic [NUM_QUEUES-1:0]                          pacing_active
);

    localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [QW-1:0]                   r_grant;
    logic [QW-1:0]                   r_last_grant;
    logic [QW-1:0]                   w_grant_next;
    logic [QW-1:0]                   w_arb_grant;
    logic [QW-1:0]                   w_idx;
    logic                            w_arb_found;
    logic                            r_first_beat;
    logic [NUM_QUEUES-1:0]           r_pkt_sent;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_bytes_sent;
    logic [NUM_QUEUES-1:0]           w_eligible;
    logic [NUM_QUEUES-1:0]           w_onehot;
    logic                            w_xfer;
    logic                            w_xfer_last;

    logic [C_AXIS_DATA_WIDTH-1:0]    w_tdata_arr [NUM_QUEUES];
    logic [SW-1:0]                   w_tstrb_arr [NUM_QUEUES];
    logic [C_AXIS_TUSER_WIDTH-1:0]   w_tuser_arr [NUM_QUEUES];

    assign w_xfer      = m_axis_tvalid & m_axis_tready;
    assign w_xfer_last = w_xfer & m_axis_tlast;
    assign w_onehot    = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << r_grant;

    // Per-queue slice unpacking and the IPD countdown; a load on tlast beats a tick.
    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
        logic [C_S_AXI_DATA_WIDTH-1:0] r_timer;

        assign w_tdata_arr[gi]   = s_axis_tdata[gi*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        assign w_tstrb_arr[gi]   = s_axis_tstrb[gi*SW +: SW];
        assign w_tuser_arr[gi]   = s_axis_tuser[gi*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        assign w_eligible[gi]    = s_axis_tvalid[gi] & (r_timer == '0);
        assign pacing_active[gi] = (r_timer != '0);

        always_ff @(posedge axi_aclk) begin
            if (!axi_resetn) begin
                r_timer <= '0;
            end else if (w_xfer_last && (r_grant == QW'(gi))) begin
                r_timer <= ipd_value[gi*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH];
            end else if (utimer_clk && (r_timer != '0)) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_grant = r_last_grant;
        w_idx       = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            w_idx = QW'((int'(r_last_grant) + k) % NUM_QUEUES);
            if (!w_arb_found && w_eligible[w_idx]) begin
                w_arb_found = 1'b1;
                w_arb_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            IDLE: begin
                if (w_arb_found) begin
                    w_state_next = SEND;
                    w_grant_next = w_arb_grant;
                end
            end
            SEND: begin
                if (w_xfer_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = w_tdata_arr[r_grant];
        m_axis_tstrb  = w_tstrb_arr[r_grant];
        m_axis_tuser  = w_tuser_arr[r_grant];
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (r_state == SEND) begin
            m_axis_tvalid          = s_axis_tvalid[r_grant];
            m_axis_tlast           = s_axis_tlast[r_grant];
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= QW'(NUM_QUEUES - 1);
            r_first_beat <= 1'b0;
            r_pkt_sent   <= '0;
            r_bytes_sent <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            if (w_xfer_last) begin
                r_last_grant <= r_grant;
            end
            if (r_state == IDLE) begin
                r_first_beat <= 1'b1;
            end else if (w_xfer) begin
                r_first_beat <= 1'b0;
            end
            if (w_xfer && r_first_beat) begin
                r_pkt_sent   <= w_onehot;
                r_bytes_sent <= {{(C_S_AXI_DATA_WIDTH-16){1'b0}}, m_axis_tuser[15:0]};
            end else begin
                r_pkt_sent   <= '0;
                r_bytes_sent <= '0;
            end
        end
    end

    assign pkt_sent   = r_pkt_sent;
    assign bytes_sent = r_bytes_sent;

endmodule
